// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipe registers and the hazard unit.
// master: pipeline side (register ids, enables); slave: hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_m;
    logic              reg_write_w;
    logic [1:0]        result_src_e;
    logic              pc_src_e;
    logic              mem_req_m;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_w;
    logic              mem_busy;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output reg_write_m, reg_write_w, result_src_e,
        output pc_src_e, mem_req_m,
        input  forward_a_e, forward_b_e,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, mem_busy,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  reg_write_m, reg_write_w, result_src_e,
        input  pc_src_e, mem_req_m,
        output forward_a_e, forward_b_e,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, mem_busy,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use, memory wait freeze, perf counters.
// Ports: clk, rst (sync, active-high), hz (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
);
    localparam bit HAS_LAT = (MEM_LAT > 0);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    logic freeze, lu;
    logic sel_rst, sel_frz, sel_br, sel_lu;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    function automatic logic [1:0] fwd(
        input logic [REG_AW-1:0] rs,
        input logic              wm,
        input logic [REG_AW-1:0] rdm,
        input logic              ww,
        input logic [REG_AW-1:0] rdw
    );
        if (wm && rdm != '0 && rdm == rs)
            return 2'b10;
        if (ww && rdw != '0 && rdw == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    assign hz.forward_a_e = fwd(hz.rs1_e, hz.reg_write_m, hz.rd_m,
                                hz.reg_write_w, hz.rd_w);
    assign hz.forward_b_e = fwd(hz.rs2_e, hz.reg_write_m, hz.rd_m,
                                hz.reg_write_w, hz.rd_w);

    assign lu = (hz.result_src_e == 2'b01) && (hz.rd_e != '0) &&
                ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    // The release cycle (WAIT, cnt==0) is not frozen: M advances at its end.
    assign freeze = (state == IDLE && hz.mem_req_m && HAS_LAT) ||
                    (state == WAIT && cnt != '0);

    // Mutually exclusive selects so the decoder below is truly one-hot.
    assign sel_rst = rst;
    assign sel_frz = !rst && freeze;
    assign sel_br  = !rst && !freeze && hz.pc_src_e;
    assign sel_lu  = !rst && !freeze && !hz.pc_src_e && lu;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        unique case (1'b1)
            sel_rst: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_w = 1'b1;
            end
            // A taken branch waits in E until the freeze releases.
            sel_frz: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end
            sel_br: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            sel_lu: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.mem_req_m && HAS_LAT) begin
                        state <= WAIT;
                        cnt   <= LAT_M1;
                    end
                end
                WAIT: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (stall_f && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (sel_br && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

    assign hz.stall_f      = stall_f;
    assign hz.stall_d      = stall_d;
    assign hz.stall_e      = stall_e;
    assign hz.stall_m      = stall_m;
    assign hz.flush_d      = flush_d;
    assign hz.flush_e      = flush_e;
    assign hz.flush_w      = flush_w;
    assign hz.mem_busy     = sel_frz;
    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_count  = flush_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: single-cycle and 3-cycle-latency controllers side by side.
// Ports: none; drives both DUTs with shared directed stimulus.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, pc_src_e, mem_req_m;
    logic [1:0] result_src_e;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) if0 ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if3 ();

    assign if0.rs1_d = rs1_d;        assign if3.rs1_d = rs1_d;
    assign if0.rs2_d = rs2_d;        assign if3.rs2_d = rs2_d;
    assign if0.rs1_e = rs1_e;        assign if3.rs1_e = rs1_e;
    assign if0.rs2_e = rs2_e;        assign if3.rs2_e = rs2_e;
    assign if0.rd_e = rd_e;          assign if3.rd_e = rd_e;
    assign if0.rd_m = rd_m;          assign if3.rd_m = rd_m;
    assign if0.rd_w = rd_w;          assign if3.rd_w = rd_w;
    assign if0.reg_write_m = reg_write_m;
    assign if3.reg_write_m = reg_write_m;
    assign if0.reg_write_w = reg_write_w;
    assign if3.reg_write_w = reg_write_w;
    assign if0.result_src_e = result_src_e;
    assign if3.result_src_e = result_src_e;
    assign if0.pc_src_e = pc_src_e;  assign if3.pc_src_e = pc_src_e;
    assign if0.mem_req_m = mem_req_m;
    assign if3.mem_req_m = mem_req_m;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .hz(if0.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .hz(if3.slave));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: pos = cycles the current access has spent in M (0 = none).
    int     lat  [2] = '{0, 3};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
    int     pos  [2] = '{0, 0};
    longint stc  [2] = '{0, 0};
    longint flc  [2] = '{0, 0};

    task automatic cmp(input string nm, input int k,
                       input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d got=%0d want=%0d", nm, k, got, want);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_frz(input int k);
        if (rst) return 1'b0;
        if (pos[k] == 0) return mem_req_m && lat[k] > 0;
        return pos[k] < lat[k];
    endfunction

    function automatic bit m_lu();
        return result_src_e == 2'b01 && rd_e != 0 &&
               (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    task automatic check_inst(input int k);
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw, mb;
        logic esf, esd, ese, esm, efd, efe, efw, emb;
        longint sc, fc;
        bit frz;
        if (k == 0) begin
            fa = if0.forward_a_e; fb = if0.forward_b_e;
            sf = if0.stall_f; sd = if0.stall_d;
            se = if0.stall_e; sm = if0.stall_m;
            fd = if0.flush_d; fe = if0.flush_e; fw = if0.flush_w;
            mb = if0.mem_busy;
            sc = longint'(if0.stall_cycles);
            fc = longint'(if0.flush_count);
        end else begin
            fa = if3.forward_a_e; fb = if3.forward_b_e;
            sf = if3.stall_f; sd = if3.stall_d;
            se = if3.stall_e; sm = if3.stall_m;
            fd = if3.flush_d; fe = if3.flush_e; fw = if3.flush_w;
            mb = if3.mem_busy;
            sc = longint'(if3.stall_cycles);
            fc = longint'(if3.flush_count);
        end
        frz = m_frz(k);
        {esf, esd, ese, esm, efd, efe, efw} = '0;
        emb = frz;
        if (rst) {efd, efe, efw} = 3'b111;
        else if (frz) {esf, esd, ese, esm, efw} = 5'b11111;
        else if (pc_src_e) {efd, efe} = 2'b11;
        else if (m_lu()) {esf, esd, efe} = 3'b111;
        cmp("fwd_a", k, fa, m_fwd(rs1_e));
        cmp("fwd_b", k, fb, m_fwd(rs2_e));
        cmp("stall", k, {sf, sd, se, sm}, {esf, esd, ese, esm});
        cmp("flush", k, {fd, fe, fw}, {efd, efe, efw});
        cmp("mem_busy", k, mb, emb);
        cmp("stall_cycles", k, sc, stc[k]);
        cmp("flush_count", k, fc, flc[k]);
    endtask

    always @(negedge clk)
        if (chk_en) begin
            check_inst(0);
            check_inst(1);
        end

    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pos[k] = 0; stc[k] = 0; flc[k] = 0;
            end else begin
                bit frz;
                frz = m_frz(k);
                if (frz || (!pc_src_e && m_lu()))
                    stc[k] = (stc[k] < cmax[k]) ? stc[k] + 1 : cmax[k];
                if (!frz && pc_src_e)
                    flc[k] = (flc[k] < cmax[k]) ? flc[k] + 1 : cmax[k];
                if (pos[k] > 0)
                    pos[k] = (pos[k] == lat[k]) ? 0 : pos[k] + 1;
                else if (frz)
                    pos[k] = 1;
            end
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {reg_write_m, reg_write_w, pc_src_e, mem_req_m} = '0;
        result_src_e = 2'b00;
    endtask

    task automatic set_lu(input logic [4:0] r);
        result_src_e = 2'b01; rd_e = r; rs2_d = r;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        #2;
        cmp("rst_flush_d", 1, if3.flush_d, 1);
        cmp("rst_busy", 1, if3.mem_busy, 0);
        cmp("rst_stc", 1, if3.stall_cycles, 0);
        cmp("rst_flc", 0, if0.flush_count, 0);
        step();
        rst = 1'b0;
        rd_m = 5; rd_w = 5; rs1_e = 5; rs2_e = 5;
        reg_write_m = 1; reg_write_w = 1;
        #2;
        cmp("lit_fwd_m", 0, if0.forward_a_e, 2'b10);
        step();
        reg_write_m = 0;
        #2;
        cmp("lit_fwd_w", 0, if0.forward_a_e, 2'b01);
        step();
        rs1_e = 0;
        #2;
        cmp("lit_fwd_x0", 0, if0.forward_a_e, 2'b00);
        cmp("lit_fwd_b_w", 1, if3.forward_b_e, 2'b01);
        step();
        clr(); set_lu(3);
        #2;
        cmp("lit_lu_stall", 0, {if0.stall_f, if0.stall_d, if0.flush_e}, 3'b111);
        step();
        clr();
        #2;
        cmp("lit_lu_cnt", 0, if0.stall_cycles, 1);
        cmp("lit_lu_cnt", 1, if3.stall_cycles, 1);
        result_src_e = 2'b01; rd_e = 0; rs1_d = 0;
        #1;
        cmp("lit_lu_x0", 0, if0.stall_f, 0);
        step();
        clr(); set_lu(3); pc_src_e = 1;
        #2;
        cmp("lit_br", 0, {if0.flush_d, if0.flush_e, if0.stall_f}, 3'b110);
        step();
        clr();
        #2;
        cmp("lit_br_cnt", 0, if0.flush_count, 1);
        mem_req_m = 1;
        #1;
        cmp("lit_frz1", 1, {if3.mem_busy, if3.stall_m, if3.flush_w}, 3'b111);
        cmp("lit_nofrz", 0, if0.mem_busy, 0);
        step();
        pc_src_e = 1;
        #2;
        cmp("lit_frz2", 1, {if3.mem_busy, if3.flush_d}, 2'b10);
        step();
        #2;
        cmp("lit_frz3", 1, {if3.mem_busy, if3.flush_d}, 2'b10);
        step();
        #2;
        cmp("lit_release", 1, {if3.mem_busy, if3.flush_d}, 2'b01);
        step();
        clr();
        #2;
        cmp("lit_frz_stc", 1, if3.stall_cycles, 4);
        cmp("lit_frz_flc", 1, if3.flush_count, 2);
        mem_req_m = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (i == 3) cmp("lit_b2b_rel", 1, if3.mem_busy, 0);
            if (i == 4) cmp("lit_b2b_frz", 1, if3.mem_busy, 1);
            step();
        end
        clr();
        step();
        mem_req_m = 1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_req_m = 0;
        #2;
        cmp("lit_rstw_busy", 1, if3.mem_busy, 0);
        cmp("lit_rstw_stc", 1, if3.stall_cycles, 0);
        cmp("lit_rstw_flc", 1, if3.flush_count, 0);
        set_lu(7);
        repeat (20) step();
        clr();
        #2;
        cmp("lit_sat", 1, if3.stall_cycles, 15);
        cmp("lit_nosat", 0, if0.stall_cycles, 20);
        for (int i = 0; i < 8; i++) begin
            step();
            rs1_e = 5'(i);      rs2_e = 5'(i ^ 1);
            rd_m = 5'(i & 6);   rd_w = 5'(i & 3);
            reg_write_m = i[0]; reg_write_w = i[1];
            rs1_d = 5'(i);      rd_e = 5'(i & 5);
            result_src_e = 2'(i & 1);
            pc_src_e = (i == 6);
        end
        step();
        clr();
        step();
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage RV32I pipeline. It sits beside the fetch/decode/execute/memory/writeback pipe registers and drives their stall and flush enables and the execute-stage forwarding muxes. It generalises hazard handling in three ways:
- parametrised register-address and counter widths;
- a wait-state FSM that freezes the whole pipeline for a configurable data-memory latency;
- saturating stall and flush performance counters.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- MEM_LAT, 0, extra wait cycles per data-memory access; 0 means single-cycle memory.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- rs1_d, rs2_d  in  REG_AW  source registers of the instruction in D.
- rs1_e, rs2_e  in  REG_AW  source registers of the instruction in E.
- rd_e, rd_m, rd_w  in  REG_AW  destination registers in E, M and W.
- reg_write_m, reg_write_w  in  1  register-write enables in M and W.
- result_src_e  in  2  result select in E; 2'b01 marks a load.
- pc_src_e  in  1  branch/jump taken, resolved in E.
- mem_req_m  in  1  load or store present in M.
- forward_a_e, forward_b_e  out  2  operand selects: 00 regfile, 10 M ALU result, 01 W result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the F/D, D/E and E/M registers.
- flush_d, flush_e, flush_w  out  1  bubble the F/D, D/E and M/W registers.
- mem_busy  out  1  memory wait in progress.
- stall_cycles, flush_count  out  CNT_W  performance counters.

## Operation
- **Forwarding (combinational).** For operand A:
  - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e;
  - otherwise 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e;
  - otherwise 00.
  - M has priority over W. Operand B uses the same rules with rs2_e.
- **Load-use (lu, combinational).** lu = (result_src_e==01) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- **Memory FSM (registered).** States IDLE and WAIT, plus a counter cnt of width clog2(MEM_LAT+1).
  - IDLE & mem_req_m & MEM_LAT>0: go to WAIT, cnt<=MEM_LAT-1.
  - WAIT & cnt!=0: cnt<=cnt-1.
  - WAIT & cnt==0: go to IDLE. This is the release cycle; the M instruction advances at its end.
  - If MEM_LAT==0, the FSM stays in IDLE permanently.
- **freeze (combinational).** freeze = (IDLE & mem_req_m & MEM_LAT>0) | (WAIT & cnt!=0). mem_busy = freeze.
- **Output priority: freeze, then flush, then lu.**
  - freeze: stall_f/d/e/m=1 and flush_w=1. flush_d=0 and flush_e=0, so a pending pc_src_e is held in E and applied after release.
  - Otherwise, if pc_src_e: flush_d=1, flush_e=1, all stalls 0.
  - Otherwise, if lu: stall_f=1, stall_d=1, flush_e=1.
  - Otherwise all stall/flush outputs are 0.
- **Reset override.** While rst is high: all stalls 0, flush_d=flush_e=flush_w=1, mem_busy=0.
- **Counters.**
  - stall_cycles increments each non-reset cycle in which stall_f=1, from either freeze or lu.
  - flush_count increments each non-reset cycle in which pc_src_e flushes. A pc_src_e held during freeze does not count.
  - Both counters saturate at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational, with zero latency from their inputs.
- FSM state and counters update on the rising edge of clk.
- **Reset values.** FSM=IDLE, cnt=0, stall_cycles=0, flush_count=0, mem_busy=0. forward_a_e and forward_b_e follow their inputs.
- **Access latency.** A memory access occupies M for exactly MEM_LAT+1 cycles: MEM_LAT frozen cycles, then one release cycle.
- **Back-to-back accesses.** A second access entering M in the cycle after release freezes immediately, with no idle gap.
- **Reset during WAIT.** The FSM returns to IDLE at the edge, so mem_busy=0 in the next cycle. The interrupted access is abandoned.
- **rd=x0.** Never forwards and never causes a load-use stall.

## Test plan
- **Forwarding priority.** rd_m=rd_w=rs1_e=5, both write enables 1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rs1_e=0 -> 00.
- **Load-use.** result_src_e=01, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for one cycle; stall_cycles increments by 1.
- **Branch flush.** pc_src_e=1 together with lu -> flush_d=flush_e=1 and stall_f=0; flush_count increments by 1.
- **MEM_LAT=3 access.** mem_req_m held -> mem_busy=1 for 3 cycles with all stalls 1 and flush_w=1, then 0 on the 4th cycle. A pc_src_e asserted during the freeze produces flush_d only in the release cycle.
- **Reset in WAIT.** MEM_LAT=3, assert rst in the 2nd wait cycle -> mem_busy=0 in the next cycle and the counters read 0.
- **Saturation.** CNT_W=4, hold lu for 20 cycles -> stall_cycles stops at 15.
